// File: rtl/led_scan_pkg.sv
// led_scan_pkg: shared state encoding, default geometry/timing and row decode helper for the LED scanner.
package led_scan_pkg;
    typedef enum logic [1:0] {IDLE, BLANK, LOAD, DRIVE} scan_state_t;
    localparam int ROWS_DEF  = 8;
    localparam int COLS_DEF  = 8;
    localparam int DWELL_DEF = 10;
    localparam int BLANK_DEF = 1;
    function automatic logic [31:0] onehot_row(input int unsigned idx);
        return 32'd1 << idx;
    endfunction
endpackage

// File: rtl/led_row_scanner_if.sv
// led_row_scanner_if: host write/swap bus plus matrix pin outputs of the LED row scanner.
interface led_row_scanner_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    logic                    wr_en;
    logic [$clog2(ROWS)-1:0] wr_row;
    logic [COLS-1:0]         wr_data;
    logic                    swap_req;
    logic [ROWS-1:0]         row_sel;
    logic [COLS-1:0]         col_data;
    logic                    frame_start;
    logic                    swap_ack;
    modport master (output wr_en, wr_row, wr_data, swap_req, input row_sel, col_data, frame_start, swap_ack);
    modport slave  (input wr_en, wr_row, wr_data, swap_req, output row_sel, col_data, frame_start, swap_ack);
endinterface

// File: rtl/led_scan_framebuf.sv
// led_scan_framebuf: dual-bank ROWS x COLS frame store; writes hit the back bank, reads see the front bank.
module led_scan_framebuf
    import led_scan_pkg::*;
#(
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [COLS-1:0]         wr_data,
    input  logic                    toggle,
    input  logic [$clog2(ROWS)-1:0] rd_row,
    output logic [COLS-1:0]         rd_data
);
    logic [COLS-1:0] mem_q [2][ROWS];
    logic [COLS-1:0] mem_d [2][ROWS];
    logic            bank_q, bank_d;
    // Back-bank write uses the pre-toggle pointer, so a write in the swap cycle lands in the new front bank.
    always_comb begin
        mem_d  = mem_q;
        bank_d = bank_q ^ toggle;
        if (wr_en && 32'(wr_row) < ROWS) mem_d[~bank_q][wr_row] = wr_data;
    end
    // Storage and bank pointer registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q  <= '{default: '0};
            bank_q <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            bank_q <= bank_d;
        end
    end
    assign rd_data = mem_q[bank_q][rd_row];
endmodule

// File: rtl/led_row_scanner.sv
// led_row_scanner: tick-timed row multiplexer for a ROWS x COLS LED matrix with frame-boundary bank swap.
// Define LED_SCAN_BRIGHTNESS_EN to add a 4-bit brightness input that limits column on-time within the dwell.
module led_row_scanner
    import led_scan_pkg::*;
#(
    parameter int ROWS        = ROWS_DEF,
    parameter int COLS        = COLS_DEF,
    parameter int DWELL_TICKS = DWELL_DEF,
    parameter int BLANK_TICKS = BLANK_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_in,
    input  logic enable,
`ifdef LED_SCAN_BRIGHTNESS_EN
    input  logic [3:0] brightness,
`endif
    led_row_scanner_if.slave bus
);
    localparam int RW = $clog2(ROWS);
    scan_state_t     state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [RW-1:0]   row_q, row_d;
    logic [COLS-1:0] lat_q, lat_d, col_data_q, col_data_d, rd_data;
    logic [ROWS-1:0] row_sel_q, row_sel_d;
    logic            frame_start_q, frame_start_d, swap_ack_q, swap_ack_d, pend_q, pend_d;
    logic            toggle, done;
`ifdef LED_SCAN_BRIGHTNESS_EN
    logic [3:0]      bri_q, bri_d;
`endif

    led_scan_framebuf #(.ROWS(ROWS), .COLS(COLS)) u_fb (
        .clk(clk), .rst(rst), .wr_en(bus.wr_en), .wr_row(bus.wr_row), .wr_data(bus.wr_data),
        .toggle(toggle), .rd_row(row_q), .rd_data(rd_data)
    );

    // Next-state, tick counting, swap arbitration and output values derived from the next state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        row_d      = row_q;
        lat_d      = lat_q;
        pend_d     = pend_q | bus.swap_req;
        swap_ack_d = 1'b0;
        toggle     = 1'b0;
        done       = tick_in && cnt_q == (state_q == DRIVE ? 8'(DWELL_TICKS - 1) : 8'(BLANK_TICKS - 1));
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            row_d   = '0;
        end else if (state_q == IDLE) begin
            state_d = BLANK;
        end else if (state_q == LOAD) begin
            state_d = DRIVE;
            lat_d   = rd_data;
        end else if (done) begin
            cnt_d   = '0;
            state_d = state_q == BLANK ? LOAD : BLANK;
            if (state_q == DRIVE) begin
                row_d = row_q == RW'(ROWS - 1) ? '0 : row_q + 1'b1;
                if (row_q == RW'(ROWS - 1) && pend_d) begin
                    toggle     = 1'b1;
                    swap_ack_d = 1'b1;
                    pend_d     = 1'b0;
                end
            end
        end else if (tick_in) begin
            cnt_d = cnt_q + 1'b1;
        end
        row_sel_d     = state_d == DRIVE ? ROWS'(onehot_row(32'(row_d))) : '0;
        frame_start_d = state_q == LOAD && state_d == DRIVE && row_q == '0;
`ifdef LED_SCAN_BRIGHTNESS_EN
        bri_d      = (state_d == LOAD && state_q != LOAD) ? brightness : bri_q;
        col_data_d = (state_d == DRIVE && cnt_d < {4'b0, bri_q}) ? lat_d : '0;
`else
        col_data_d = state_d == DRIVE ? lat_d : '0;
`endif
    end

    // State, counters, swap flag and registered pin outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            row_q         <= '0;
            lat_q         <= '0;
            pend_q        <= 1'b0;
            swap_ack_q    <= 1'b0;
            row_sel_q     <= '0;
            col_data_q    <= '0;
            frame_start_q <= 1'b0;
`ifdef LED_SCAN_BRIGHTNESS_EN
            bri_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            row_q         <= row_d;
            lat_q         <= lat_d;
            pend_q        <= pend_d;
            swap_ack_q    <= swap_ack_d;
            row_sel_q     <= row_sel_d;
            col_data_q    <= col_data_d;
            frame_start_q <= frame_start_d;
`ifdef LED_SCAN_BRIGHTNESS_EN
            bri_q         <= bri_d;
`endif
        end
    end

    assign bus.row_sel     = row_sel_q;
    assign bus.col_data    = col_data_q;
    assign bus.frame_start = frame_start_q;
    assign bus.swap_ack    = swap_ack_q;
endmodule
